// File: rtl/fetch_splitter.sv
// rtl/fetch_splitter.sv - splits 2-slot fetch packets into single-instruction FIFO entries
module fetch_splitter #(
  parameter int PC_W    = 32,
  parameter int ENTRY_W = 3*PC_W+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_inst0,
  input  logic [PC_W-1:0]    in_inst1,
  input  logic [1:0]         in_mask,
  input  logic               in_pred_taken,
  input  logic               in_pred_slot,
  input  logic [PC_W-1:0]    in_pred_target,
  input  logic               fifo_full,
  input  logic               fifo_stall,
  output logic               push_en,
  output logic [ENTRY_W-1:0] push_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, inst0_q, inst1_q, target_q;
  logic [1:0]        emask_q;
  logic              ptaken_q, pslot_q;

  logic [1:0]        cap_emask;
  logic              cap_ptaken;
  logic              emitting, last_fire, accept, slot;
  logic [PC_W-1:0]   entry_pc, entry_inst, entry_target;
  logic              entry_taken;

  // A taken branch in slot 0 kills slot 1; a prediction on a masked-off slot 1 is meaningless.
  always_comb begin
    cap_emask  = in_mask;
    cap_ptaken = in_pred_taken;
    if (in_pred_taken && !in_pred_slot)
      cap_emask[1] = 1'b0;
    if (in_pred_taken && in_pred_slot && !in_mask[1])
      cap_ptaken = 1'b0;
  end

  assign emitting  = (state_q == EMIT0) || (state_q == EMIT1);
  assign push_en   = emitting && !fifo_full && !flush;
  assign last_fire = push_en && ((state_q == EMIT1) || !emask_q[1]);
  assign in_ready  = !flush && !fifo_stall && ((state_q == IDLE) || last_fire);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);

  assign slot         = (state_q == EMIT1);
  assign entry_pc     = slot ? pc_q + PC_W'(4) : pc_q;
  assign entry_inst   = slot ? inst1_q : inst0_q;
  assign entry_taken  = ptaken_q && (pslot_q == slot);
  assign entry_target = entry_taken ? target_q : entry_pc + PC_W'(4);
  assign push_data    = push_en ? {entry_pc, entry_inst, entry_target, entry_taken}
                                : '0;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      if (cap_emask[0])
        state_d = EMIT0;
      else if (cap_emask[1])
        state_d = EMIT1;
      else
        state_d = IDLE;
    end else if (push_en) begin
      if (state_q == EMIT0 && emask_q[1])
        state_d = EMIT1;
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      inst0_q  <= '0;
      inst1_q  <= '0;
      target_q <= '0;
      emask_q  <= '0;
      ptaken_q <= 1'b0;
      pslot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q     <= in_pc;
        inst0_q  <= in_inst0;
        inst1_q  <= in_inst1;
        target_q <= in_pred_target;
        emask_q  <= cap_emask;
        ptaken_q <= cap_ptaken;
        pslot_q  <= in_pred_slot;
      end
    end
  end

endmodule

// File: tb/tb_fetch_splitter.sv
// tb/tb_fetch_splitter.sv - randomized check of fetch_splitter against a pending-entry list model
module tb_fetch_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst0, in_inst1, in_pred_target;
  logic [1:0]  in_mask;
  logic        in_pred_taken, in_pred_slot;
  logic        fifo_full, fifo_stall;
  logic        push_en, busy;
  logic [96:0] push_data;

  int errors = 0;
  int checks = 0;
  logic [96:0] pend[$];
  int pushes = 0;

  always #5 clk = ~clk;

  fetch_splitter dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst0(in_inst0), .in_inst1(in_inst1), .in_mask(in_mask),
    .in_pred_taken(in_pred_taken), .in_pred_slot(in_pred_slot),
    .in_pred_target(in_pred_target), .fifo_full(fifo_full), .fifo_stall(fifo_stall),
    .push_en(push_en), .push_data(push_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [96:0] got, input logic [96:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: a packet becomes the list of FIFO entries it should produce, in order.
  task automatic load_packet();
    bit [31:0] spc, inst, tgt;
    bit        tk;
    pend.delete();
    for (int s = 0; s < 2; s++) begin
      if (!in_mask[s]) continue;
      if (s == 1 && in_pred_taken && !in_pred_slot) continue;
      spc  = in_pc + 32'(4 * s);
      inst = (s == 0) ? in_inst0 : in_inst1;
      tk   = in_pred_taken && (int'(in_pred_slot) == s);
      tgt  = tk ? in_pred_target : spc + 32'd4;
      pend.push_back({spc, inst, tgt, tk});
    end
  endtask

  task automatic step();
    bit exp_ready, exp_push;
    @(negedge clk);
    exp_push  = (pend.size() > 0) && !fifo_full && !flush;
    exp_ready = !flush && !fifo_stall &&
                (pend.size() == 0 || (pend.size() == 1 && exp_push));
    check("push_en", 97'(push_en), 97'(exp_push));
    check("push_data", push_data, exp_push ? pend[0] : 97'd0);
    check("in_ready", 97'(in_ready), 97'(exp_ready));
    check("busy", 97'(busy), 97'(pend.size() != 0));
    if (flush) begin
      pend.delete();
    end else begin
      if (exp_push) begin
        void'(pend.pop_front());
        pushes++;
      end
      if (in_valid && exp_ready) load_packet();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input bit [31:0] pc, input bit [1:0] mask,
                         input bit tk, input bit ps, input bit [31:0] tgt);
    in_valid = 1'b1; in_pc = pc; in_mask = mask;
    in_inst0 = 32'h02800421; in_inst1 = 32'h02800842;
    in_pred_taken = tk; in_pred_slot = ps; in_pred_target = tgt;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst0 = '0; in_inst1 = '0;
    in_mask = '0; in_pred_taken = 1'b0; in_pred_slot = 1'b0; in_pred_target = '0;
    fifo_full = 1'b0; fifo_stall = 1'b0;
    #12;
    check("rst_push_en", 97'(push_en), 97'd0);
    check("rst_push_data", push_data, 97'd0);
    check("rst_busy", 97'(busy), 97'd0);
    check("rst_in_ready", 97'(in_ready), 97'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Basic split, then taken-in-slot-0
    set_pkt(32'h1C000000, 2'b11, 1'b0, 1'b0, 32'h0); step();
    idle_steps(3);
    set_pkt(32'h1C000000, 2'b11, 1'b1, 1'b0, 32'h1C000100); step();
    idle_steps(2);

    // Full backpressure during EMIT0
    set_pkt(32'h1C000040, 2'b11, 1'b0, 1'b0, 32'h0); step();
    in_valid = 1'b0; fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fifo_full = 1'b0; idle_steps(3);

    // Almost-full in IDLE blocks capture until it clears
    fifo_stall = 1'b1; set_pkt(32'h1C000080, 2'b01, 1'b0, 1'b0, 32'h0); step(); step();
    fifo_stall = 1'b0; step(); idle_steps(2);

    // Mask cases and PC wrap
    set_pkt(32'h1C000008, 2'b10, 1'b0, 1'b0, 32'h0); step(); idle_steps(2);
    set_pkt(32'h1C000010, 2'b00, 1'b0, 1'b0, 32'h0); step(); idle_steps(1);
    set_pkt(32'hFFFFFFFC, 2'b11, 1'b0, 1'b0, 32'h0); step(); idle_steps(3);
    set_pkt(32'h1C000020, 2'b01, 1'b1, 1'b1, 32'h12345678); step(); idle_steps(2);

    // Flush in EMIT0
    set_pkt(32'h1C000200, 2'b11, 1'b0, 1'b0, 32'h0); step();
    in_valid = 1'b1; flush = 1'b1; step();
    flush = 1'b0; idle_steps(3);

    // Asynchronous reset mid-packet
    set_pkt(32'h1C000300, 2'b11, 1'b0, 1'b0, 32'h0); step();
    in_valid = 1'b0; #2; rst = 1'b0; #1;
    check("arst_push_en", 97'(push_en), 97'd0);
    check("arst_push_data", push_data, 97'd0);
    check("arst_busy", 97'(busy), 97'd0);
    check("arst_in_ready", 97'(in_ready), 97'd1);
    pend.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    idle_steps(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      in_inst0       = $urandom();
      in_inst1       = $urandom();
      in_mask        = 2'($urandom_range(0, 3));
      in_pred_taken  = ($urandom_range(0, 2) == 0);
      in_pred_slot   = 1'($urandom_range(0, 1));
      in_pred_target = $urandom();
      fifo_full      = ($urandom_range(0, 3) == 0);
      fifo_stall     = ($urandom_range(0, 4) == 0);
      flush          = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0; fifo_stall = 1'b0;
    idle_steps(3);
    check("pushes_seen", 97'(pushes > 100), 97'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_splitter.md
Name: fetch_splitter

Overview:
- Sits between the I-cache/branch-predictor fetch stage and the 16-entry instruction FIFO.
- Accepts one 2-instruction fetch packet per handshake and serializes it into single-instruction 97-bit FIFO entries, at most one per cycle.
- Drops masked-off slots and any slot following a predicted-taken branch.
- Honours the FIFO's full and almost-full (stall) indications, so the FIFO never silently drops a push.

Parameters:
- PC_W, 32, width of PC, instruction and target fields.
- ENTRY_W, 97, FIFO entry width; fixed as 3*PC_W+1.

Ports:
- clk  input  1  single system clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush (redirect); same cycle as the FIFO's flush.
- in_valid  input  1  fetch packet valid.
- in_ready  output  1  packet accepted when in_valid & in_ready.
- in_pc  input  32  PC of slot 0; slot 1 PC = in_pc+4.
- in_inst0  input  32  slot 0 instruction.
- in_inst1  input  32  slot 1 instruction.
- in_mask  input  2  per-slot valid; bit0 = slot 0.
- in_pred_taken  input  1  predictor says a branch in this packet is taken.
- in_pred_slot  input  1  slot holding the taken branch.
- in_pred_target  input  32  predicted target of that branch.
- fifo_full  input  1  FIFO full (15 of 16 used).
- fifo_stall  input  1  FIFO almost-full (14 used).
- push_en  output  1  FIFO push strobe.
- push_data  output  97  {pc[96:65], inst[64:33], pred_target[32:1], pred_taken[0]}.
- busy  output  1  packet held with slots still to emit.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; holding registers cleared to 0.
  - push_en=0, push_data=0, busy=0.
  - in_ready = !flush & !fifo_stall.
- Effective mask on capture:
  - emask = in_mask.
  - If in_pred_taken & in_pred_slot==0, emask[1] is forced to 0.
  - If in_pred_taken & in_pred_slot==1 & !in_mask[1], the prediction is discarded (pred_taken treated 0).
- States: IDLE, EMIT0, EMIT1.
- Accept = in_valid & in_ready. On accept, register pc, insts, emask, pred fields. Next state:
  - EMIT0 if emask[0];
  - else EMIT1 if emask[1];
  - else IDLE (empty packet consumed, nothing pushed).
- Emitting:
  - push_en = (state==EMIT0 | state==EMIT1) & !fifo_full & !flush. This is combinational from registered state, so latency from accept to first push is 1 cycle.
  - EMIT0 fields: pc = held pc; inst = inst0.
  - EMIT1 fields: pc = held pc+4; inst = inst1.
  - Predicted slot entry: pred_taken = 1, pred_target = held target.
  - Every other entry: pred_taken = 0, pred_target = entry pc+4 (32-bit wrap; no carry-out).
  - Once a push fires: EMIT0 -> EMIT1 if emask[1], else IDLE. EMIT1 -> IDLE.
- Fire and hold:
  - fifo_full=1: no push; state and push_data held stable.
  - push_data is driven 0 when push_en=0.
- Ready:
  - in_ready = !flush & !fifo_stall & (state==IDLE | last_fire).
  - last_fire = push_en and the current slot is the last set bit of emask.
  - Back-to-back is allowed: if last_fire and accept occur in the same cycle, the new packet loads and the next state follows the new emask. This gives 1 entry/cycle sustained for single-slot packets.
- busy = (state != IDLE).
- Flush:
  - Same cycle: push_en=0, in_ready=0.
  - Next cycle: state=IDLE and any held packet is discarded.
  - A flush concurrent with in_valid does not accept the packet.
- Reset mid-packet: immediate return to IDLE; held slots are lost.

Test Plan:
- Basic split: in_pc=0x1C000000, inst0=0x02800421, inst1=0x02800842, mask=2'b11, no pred.
  - Two consecutive pushes.
  - push_data = {0x1C000000, 0x02800421, 0x1C000004, 0} then {0x1C000004, 0x02800842, 0x1C000008, 0}.
  - in_ready=1 in the cycle of the second push.
- Taken in slot 0: pred_taken=1, pred_slot=0, target=0x1C000100, mask=11.
  - Exactly one push: {pc0, inst0, 0x1C000100, 1}.
  - Slot 1 never pushed; state returns to IDLE.
- Full backpressure: fifo_full=1 for 3 cycles during EMIT0.
  - push_en=0 and busy=1 for those cycles; no state change.
  - Push fires in the cycle fifo_full drops, with unchanged data.
- Almost-full: fifo_stall=1 in IDLE with in_valid=1 -> in_ready=0 and no capture. When fifo_stall clears, the packet is accepted.
- Mask cases:
  - mask=2'b10, pc=0x1C000008: single push with pc 0x1C00000C.
  - mask=00: accepted, no push.
  - PC wrap: pc=0xFFFFFFFC, mask=11 -> second entry pc=0x00000000, pred_target=0x00000004.
- Flush/reset: assert flush in EMIT0 of a 2-slot packet.
  - push_en=0 that cycle; IDLE next cycle; no further pushes.
  - Repeat with rst=0 mid-packet: outputs immediately return to reset values.
